// File: rtl/adpll_loop_filter.sv
// ---------------------------------------------------------------------------
// adpll_loop_filter
//
// Purpose:
//   Gear-shifted digital PI loop filter placed directly after the ADPLL
//   two-level TDC. Each reference sample of the 10-bit {coarse,fine} phase
//   word is turned into a signed error against the expected count FCW. That
//   error drives a saturating integrator and a proportional path. Together
//   they produce a clamped DCO tuning word.
//
//   A built-in lock detector switches between two gain sets:
//     - ACQ uses high gains (small right-shifts).
//     - TRACK uses low gains (large right-shifts).
//   The integrator carries across gear changes without rescaling. Everything
//   runs in the ref_clk domain.
//
//   Pipeline:
//     - Stage 1 registers the error.
//     - Stage 2 updates the integrator, dco_ctrl, the lock counter and the
//       state.
//   So a sample shows on dco_ctrl two ref_clk edges after pe_valid.
//
// Optional feature:
//   When the ADPLL_LF_FREEZE_EN macro is defined, the module gains an input
//   port called freeze. While freeze is high, stage 2 ignores samples. Dropping
//   en still forces IDLE, and reset still wins.
//
// Ports:
//   ref_clk      in   sole clock, rising edge
//   reset        in   asynchronous, active-high
//   en           in   loop enable; 0 forces IDLE on the next edge
//   pe_valid     in   phase_error carries a new sample this cycle
//   freeze       in   (ADPLL_LF_FREEZE_EN only) hold the loop state
//   phase_error  in   [9:0]  TDC output {coarse[7:0],fine[1:0]}, unsigned
//   dco_ctrl     out  [CTRL_W-1:0] DCO tuning word, unsigned
//   locked       out  1 while the FSM is in TRACK (registered)
//   state        out  [1:0] 00 IDLE, 01 ACQ, 10 TRACK
// ---------------------------------------------------------------------------
module adpll_loop_filter #(
  parameter int FCW        = 512,
  parameter int CTRL_W     = 12,
  parameter int CENTER     = 2048,
  parameter int ACC_W      = 16,
  parameter int KP_ACQ     = 2,
  parameter int KI_ACQ     = 4,
  parameter int KP_TRK     = 4,
  parameter int KI_TRK     = 6,
  parameter int LOCK_TOL   = 4,
  parameter int UNLOCK_TOL = 32,
  parameter int LOCK_CNT   = 16
) (
  input  logic              ref_clk,
  input  logic              reset,
  input  logic              en,
  input  logic              pe_valid,
`ifdef ADPLL_LF_FREEZE_EN
  input  logic              freeze,
`endif
  input  logic [9:0]        phase_error,
  output logic [CTRL_W-1:0] dco_ctrl,
  output logic              locked,
  output logic [1:0]        state
);

  // Three guard bits above the wider of the accumulator and the output.
  // This keeps CENTER + P + I from ever wrapping.
  localparam int SUM_W      = ((ACC_W > CTRL_W) ? ACC_W : CTRL_W) + 3;
  localparam int CNT_W      = $clog2(LOCK_CNT + 1);
  localparam int ACC_MAX_I  = (1 << (ACC_W - 1)) - 1;
  localparam int CTRL_MAX_I = (1 << CTRL_W) - 1;

  localparam logic signed [SUM_W-1:0] ACC_MAX  = SUM_W'(ACC_MAX_I);
  localparam logic signed [SUM_W-1:0] ACC_MIN  = SUM_W'(-ACC_MAX_I - 1);
  localparam logic signed [SUM_W-1:0] CTRL_MAX = SUM_W'(CTRL_MAX_I);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ACQ   = 2'b01,
    TRACK = 2'b10
  } lfState_t;

  lfState_t                 r_state;
  lfState_t                 w_stateNext;
  logic signed [10:0]       r_errQ;
  logic                     r_vQ;
  logic signed [ACC_W-1:0]  r_integ;
  logic signed [ACC_W-1:0]  w_integNext;
  logic signed [ACC_W-1:0]  w_integNew;
  logic [CNT_W-1:0]         r_cnt;
  logic [CNT_W-1:0]         w_cntNext;
  logic [CNT_W-1:0]         w_cntInc;
  logic [CTRL_W-1:0]        r_dcoCtrl;
  logic [CTRL_W-1:0]        w_dcoNext;
  logic [CTRL_W-1:0]        w_dcoNew;
  logic                     r_locked;
  logic                     w_take;
  logic [3:0]               w_kp;
  logic [3:0]               w_ki;
  logic [10:0]              w_errMag;
  logic signed [SUM_W-1:0]  w_errExt;
  logic signed [SUM_W-1:0]  w_integRaw;
  logic signed [SUM_W-1:0]  w_sum;

`ifdef ADPLL_LF_FREEZE_EN
  assign w_take = r_vQ & ~freeze;
`else
  assign w_take = r_vQ;
`endif

  // Stage 1: turn the unsigned TDC word into a signed error around FCW.
  // The error is only refreshed on a valid sample; otherwise it holds.
  always_ff @(posedge ref_clk or posedge reset) begin
    if (reset) begin
      r_errQ <= '0;
      r_vQ   <= 1'b0;
    end else begin
      r_vQ <= pe_valid;
      if (pe_valid) begin
        r_errQ <= {1'b0, phase_error} - 11'(FCW);
      end
    end
  end

  // Datapath for stage 2. The gears are chosen from the current state, before
  // any update. Signed >>> gives floor rounding toward minus infinity. The
  // integrator saturates before it is added into the output sum.
  always_comb begin
    w_kp = (r_state == TRACK) ? 4'(KP_TRK) : 4'(KP_ACQ);
    w_ki = (r_state == TRACK) ? 4'(KI_TRK) : 4'(KI_ACQ);
    w_errExt   = SUM_W'(r_errQ);
    w_integRaw = SUM_W'(r_integ) + (w_errExt >>> w_ki);
    if (w_integRaw > ACC_MAX) begin
      w_integNew = ACC_MAX[ACC_W-1:0];
    end else if (w_integRaw < ACC_MIN) begin
      w_integNew = ACC_MIN[ACC_W-1:0];
    end else begin
      w_integNew = w_integRaw[ACC_W-1:0];
    end
    w_sum = SUM_W'(CENTER) + (w_errExt >>> w_kp) + SUM_W'(w_integNew);
    if (w_sum[SUM_W-1]) begin
      w_dcoNew = '0;
    end else if (w_sum > CTRL_MAX) begin
      w_dcoNew = CTRL_MAX[CTRL_W-1:0];
    end else begin
      w_dcoNew = w_sum[CTRL_W-1:0];
    end
    // The error can never be -1024, so an 11-bit magnitude is exact.
    w_errMag = r_errQ[10] ? 11'(-r_errQ) : 11'(r_errQ);
    w_cntInc = r_cnt + 1'b1;
  end

  // Next-state logic for the FSM and the loop state.
  // Dropping en overrides everything, including a sample landing on the same
  // edge. The first edge out of IDLE also discards any sample in flight.
  always_comb begin
    w_stateNext = r_state;
    w_integNext = r_integ;
    w_cntNext   = r_cnt;
    w_dcoNext   = r_dcoCtrl;
    if (!en) begin
      w_stateNext = IDLE;
      w_integNext = '0;
      w_cntNext   = '0;
      w_dcoNext   = CTRL_W'(CENTER);
    end else begin
      case (r_state)
        IDLE: begin
          w_stateNext = ACQ;
          w_integNext = '0;
          w_cntNext   = '0;
          w_dcoNext   = CTRL_W'(CENTER);
        end
        ACQ: begin
          if (w_take) begin
            w_integNext = w_integNew;
            w_dcoNext   = w_dcoNew;
            if (w_errMag <= 11'(LOCK_TOL)) begin
              if (w_cntInc == CNT_W'(LOCK_CNT)) begin
                w_stateNext = TRACK;
                w_cntNext   = '0;
              end else begin
                w_cntNext = w_cntInc;
              end
            end else begin
              w_cntNext = '0;
            end
          end
        end
        TRACK: begin
          if (w_take) begin
            w_integNext = w_integNew;
            w_dcoNext   = w_dcoNew;
            if (w_errMag > 11'(UNLOCK_TOL)) begin
              w_stateNext = ACQ;
              w_cntNext   = '0;
            end
          end
        end
        default: begin
          w_stateNext = IDLE;
          w_integNext = '0;
          w_cntNext   = '0;
          w_dcoNext   = CTRL_W'(CENTER);
        end
      endcase
    end
  end

  // Stage 2 registers. locked is derived from the next state, so it changes
  // on the same edge as state.
  always_ff @(posedge ref_clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_integ   <= '0;
      r_cnt     <= '0;
      r_dcoCtrl <= CTRL_W'(CENTER);
      r_locked  <= 1'b0;
    end else begin
      r_state   <= w_stateNext;
      r_integ   <= w_integNext;
      r_cnt     <= w_cntNext;
      r_dcoCtrl <= w_dcoNext;
      r_locked  <= (w_stateNext == TRACK);
    end
  end

  assign dco_ctrl = r_dcoCtrl;
  assign locked   = r_locked;
  assign state    = r_state;

endmodule

// File: tb/tb_adpll_loop_filter.sv
// ---------------------------------------------------------------------------
// tb_adpll_loop_filter
//
// Purpose:
//   Self-checking bench for adpll_loop_filter in its default build, without
//   the freeze port.
//
//   Stimulus is applied on falling edges. Each valid sample is run through an
//   integer reference model of the PI loop and its lock detector. The expected
//   {dco_ctrl, state, locked} is pushed into a queue, tagged with the cycle on
//   which it must appear. A separate monitor pops and compares on falling
//   edges. Reset values are checked directly while reset is asserted.
// ---------------------------------------------------------------------------
module tb_adpll_loop_filter;

  localparam int FCW = 512;

  logic        ref_clk = 1'b0;
  logic        reset;
  logic        en;
  logic        pe_valid;
  logic [9:0]  phase_error;
  logic [11:0] dco_ctrl;
  logic        locked;
  logic [1:0]  state;

  typedef struct {
    int due;
    int dco;
    int st;
    int lk;
    int id;
  } exp_t;

  exp_t sbQ[$];
  int   cycle    = 0;
  int   checks   = 0;
  int   failures = 0;
  int   nextId   = 0;

  // Reference model state: 0 IDLE, 1 ACQ, 2 TRACK.
  int mState = 0;
  int mInteg = 0;
  int mCnt   = 0;
  int mDco   = 2048;

  adpll_loop_filter dut (
    .ref_clk     (ref_clk),
    .reset       (reset),
    .en          (en),
    .pe_valid    (pe_valid),
    .phase_error (phase_error),
    .dco_ctrl    (dco_ctrl),
    .locked      (locked),
    .state       (state)
  );

  // 100 MHz reference clock.
  always #5 ref_clk = ~ref_clk;

  // Count rising edges so expected results can be tied to an exact cycle.
  always @(posedge ref_clk) cycle <= cycle + 1;

  // Floor division by a power of two, done with plain integer arithmetic.
  function automatic int floorDiv(input int v, input int s);
    int d;
    d = 1 << s;
    if (v >= 0) return v / d;
    return -((-v + d - 1) / d);
  endfunction

  function automatic int clampInt(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  // Put the model into fresh acquisition, as after IDLE with en high.
  task automatic modelAcq();
    mState = 1;
    mInteg = 0;
    mCnt   = 0;
    mDco   = 2048;
  endtask

  // One sample through the loop, using the gear of the current state.
  task automatic modelSample(input int err);
    int kp;
    int ki;
    int mag;
    kp = (mState == 2) ? 4 : 2;
    ki = (mState == 2) ? 6 : 4;
    mInteg = clampInt(mInteg + floorDiv(err, ki), -32768, 32767);
    mDco   = clampInt(2048 + floorDiv(err, kp) + mInteg, 0, 4095);
    mag    = (err < 0) ? -err : err;
    if (mState == 1) begin
      if (mag <= 4) begin
        mCnt++;
        if (mCnt == 16) begin
          mState = 2;
          mCnt   = 0;
        end
      end else begin
        mCnt = 0;
      end
    end else if (mState == 2) begin
      if (mag > 32) begin
        mState = 1;
        mCnt   = 0;
      end
    end
  endtask

  task automatic pushExpect(input int dueCycle);
    exp_t e;
    e.due = dueCycle;
    e.dco = mDco;
    e.st  = mState;
    e.lk  = (mState == 2) ? 1 : 0;
    e.id  = nextId;
    nextId++;
    sbQ.push_back(e);
  endtask

  task automatic checkOutput(input string name, input int id, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("[TB] FAIL %s #%0d actual=%0d required=%0d", name, id, act, req);
    end
  endtask

  // Drive one cycle of stimulus. A valid sample becomes visible after the
  // second rising edge from now.
  task automatic applyStimulus(input logic v, input int pe);
    @(negedge ref_clk);
    pe_valid    = v;
    phase_error = 10'(pe);
    if (v) begin
      modelSample(pe - FCW);
      pushExpect(cycle + 2);
    end
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 0);
  endtask

  // Pulse en low for one cycle. IDLE is expected after the next edge, and the
  // loop restarts in ACQ from a cleared integrator.
  task automatic restartLoop();
    idleCycles(2);
    @(negedge ref_clk);
    pe_valid = 1'b0;
    en       = 1'b0;
    mState = 0;
    mInteg = 0;
    mCnt   = 0;
    mDco   = 2048;
    pushExpect(cycle + 1);
    @(negedge ref_clk);
    en = 1'b1;
    modelAcq();
  endtask

  // Monitor: whenever an expected response is due, compare it with the DUT.
  initial begin
    exp_t e;
    forever begin
      @(negedge ref_clk);
      while (sbQ.size() > 0 && sbQ[0].due <= cycle) begin
        e = sbQ.pop_front();
        checkOutput("dco_ctrl", e.id, int'(dco_ctrl), e.dco);
        checkOutput("state", e.id, int'(state), e.st);
        checkOutput("locked", e.id, int'(locked), e.lk);
      end
    end
  end

  // Main stimulus sequence.
  initial begin
    int r;
    int pe;
    logic v;
    reset       = 1'b1;
    en          = 1'b0;
    pe_valid    = 1'b0;
    phase_error = '0;
    repeat (2) @(negedge ref_clk);
    checkOutput("reset_dco", -1, int'(dco_ctrl), 2048);
    checkOutput("reset_locked", -1, int'(locked), 0);
    checkOutput("reset_state", -1, int'(state), 0);
    reset = 1'b0;

    // Enable, then a +16 sample followed by a zero-error sample.
    @(negedge ref_clk);
    en = 1'b1;
    modelAcq();
    applyStimulus(1'b1, 528);
    applyStimulus(1'b1, 512);

    // Negative errors from fresh ACQ exercise the floor shifts.
    restartLoop();
    applyStimulus(1'b1, 496);
    restartLoop();
    applyStimulus(1'b1, 511);
    applyStimulus(1'b1, 496);

    // Lock detection: 15 in tolerance and one at err 8 must not lock. A full
    // run of 16 must lock, and a large error must drop back to ACQ.
    restartLoop();
    for (int i = 0; i < 15; i++) applyStimulus(1'b1, 514);
    applyStimulus(1'b1, 520);
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 514);
    applyStimulus(1'b1, 510);
    applyStimulus(1'b1, 600);
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 514);

    // In TRACK, drop en on the same edge where the stage-2 sample lands.
    @(negedge ref_clk);
    pe_valid    = 1'b1;
    phase_error = 10'd514;
    @(negedge ref_clk);
    pe_valid = 1'b0;
    en       = 1'b0;
    mState = 0;
    mInteg = 0;
    mCnt   = 0;
    mDco   = 2048;
    pushExpect(cycle + 1);
    @(negedge ref_clk);
    en = 1'b1;
    modelAcq();
    applyStimulus(1'b1, 528);

    // Randomised samples, mostly near lock, with random gaps.
    for (int i = 0; i < 600; i++) begin
      v = ($urandom_range(0, 3) != 0);
      r = int'($urandom_range(0, 9));
      if (r < 7) pe = FCW + int'($urandom_range(0, 12)) - 6;
      else pe = int'($urandom_range(0, 1023));
      applyStimulus(v, pe);
    end

    // Asynchronous reset mid-run while dco_ctrl sits off centre.
    restartLoop();
    applyStimulus(1'b1, 528);
    idleCycles(3);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_reset_dco", -2, int'(dco_ctrl), 2048);
    checkOutput("async_reset_locked", -2, int'(locked), 0);
    checkOutput("async_reset_state", -2, int'(state), 0);
    @(negedge ref_clk);
    reset = 1'b0;
    modelAcq();

    // Saturation: full-scale positive error, then full-scale negative error.
    for (int i = 0; i < 2000; i++) applyStimulus(1'b1, 1023);
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 0);
    idleCycles(1);

    // Drain the scoreboard, within a bounded number of cycles.
    for (int i = 0; i < 10 && sbQ.size() > 0; i++) @(negedge ref_clk);
    if (sbQ.size() > 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL drain pending=%0d required=0", sbQ.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adpll_loop_filter.md
Name: adpll_loop_filter

Overview:
Digital PI loop filter directly downstream of the ADPLL two-level TDC. It consumes the TDC's 10-bit {coarse,fine} phase_error word once per reference sample, subtracts the expected count, and produces the saturating DCO tuning word. Gain is gear-shifted: ACQ uses high gains, TRACK uses low gains, selected by an integrated lock detector. Runs entirely in the ref_clk domain.

Parameters:
FCW, 512, expected phase_error value at lock (10-bit unsigned)
CTRL_W, 12, dco_ctrl width
CENTER, 2048, dco_ctrl value in IDLE/after reset
ACC_W, 16, signed integrator width
KP_ACQ, 2, proportional right-shift in ACQ
KI_ACQ, 4, integral right-shift in ACQ
KP_TRK, 4, proportional right-shift in TRACK
KI_TRK, 6, integral right-shift in TRACK
LOCK_TOL, 4, |err| <= this counts toward lock
UNLOCK_TOL, 32, |err| > this in TRACK forces ACQ
LOCK_CNT, 16, consecutive in-tolerance samples needed for lock

Ports:
ref_clk  input  1  sole clock, rising edge
reset  input  1  asynchronous, active-high
en  input  1  loop enable; 0 forces IDLE
pe_valid  input  1  phase_error holds a new sample this cycle
phase_error  input  10  TDC output {coarse[7:0],fine[1:0]}, unsigned
dco_ctrl  output  CTRL_W  DCO tuning word, unsigned
locked  output  1  1 while FSM is in TRACK
state  output  2  00 IDLE, 01 ACQ, 10 TRACK

Behaviour:
- Reset (async, any time): dco_ctrl=CENTER, locked=0, state=IDLE, integrator=0, lock counter=0, pipeline valid=0.
- Stage 1 (edge N, pe_valid=1): err_q = {1'b0,phase_error} - FCW, 11-bit signed; v_q=1. pe_valid=0 -> v_q=0, err_q holds.
- Stage 2 (edge N+1, v_q=1, state!=IDLE): gains from current state (pre-update). integ_n = sat_ACC_W(integ + (err_q >>> KI)); sum = CENTER + (err_q >>> KP) + integ_n; dco_ctrl = clamp(sum, 0, 2^CTRL_W-1). All shifts arithmetic (floor toward -inf). Intermediate sum width >= max(ACC_W,CTRL_W)+2; no wrap anywhere.
- Latency: dco_ctrl reflects a sample exactly 2 ref_clk edges after pe_valid. No sample -> dco_ctrl and integ hold.
- FSM (updates at stage 2 on v_q=1, except en):
  IDLE: dco_ctrl=CENTER, integ=0, cnt=0. en=1 -> ACQ next edge (samples in flight while IDLE are discarded).
  ACQ: |err_q|<=LOCK_TOL -> cnt+1, else cnt=0. cnt reaching LOCK_CNT on this sample -> TRACK, cnt=0.
  TRACK: |err_q|>UNLOCK_TOL -> ACQ, cnt=0. Integrator carried across gear changes (no rescale, output continuous apart from the P term).
  en=0 in any state -> IDLE on the next edge, overriding a concurrent sample; integ cleared, dco_ctrl=CENTER.
- locked is registered: it equals (state==TRACK) and changes on the same edge as the state.
- |err_q| for err_q=-1024 cannot occur (range -FCW..1023-FCW); compare uses 11-bit magnitude.

Optional Feature:
Macro ADPLL_LF_FREEZE_EN. Defined: adds input port freeze (1 bit, after pe_valid). While freeze=1, stage 2 ignores samples: integ, dco_ctrl, cnt and state hold; en=0 still forces IDLE; reset still wins. Not defined: no freeze port, behaviour as above.

Test Plan:
Assert reset mid-run with dco_ctrl!=CENTER -> immediately dco_ctrl=2048, locked=0, state=00, no ref_clk edge needed.
en=1, one sample phase_error=528 (err=+16) in ACQ -> 2 edges later dco_ctrl=2048+4+1=2053; next sample phase_error=512 -> dco_ctrl=2049 (integ holds 1).
From fresh ACQ, phase_error=496 (err=-16) -> dco_ctrl=2043; phase_error=511 (err=-1) -> P=-1, integ +=-1 -> dco_ctrl=2046 (floor shift check).
16 consecutive samples phase_error=514 -> locked rises with the 16th sample's stage 2 edge, state=10; 15 then one at 520 (err 8) -> counter restarts, no lock; in TRACK, phase_error=600 (err 88) -> state=01, locked=0.
Hold phase_error=1023 for 2000 samples -> dco_ctrl pins at 4095, integ stops at 32767 (no wrap); then phase_error=0 -> dco_ctrl decreases monotonically from next sample.
en dropped same cycle as stage-2 sample in TRACK -> next edge state=00, dco_ctrl=2048, locked=0; re-enable -> ACQ with integ=0.
